// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and default bit timing.
package uart_tx_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO decoupling CPU stores from the transmit shift engine; dout is the combinational head.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: FIFO-buffered bytes shifted out LSB first with a registered tx line.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  output logic       full,
  output logic       busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  tx_state_e  state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       fifo_pop;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       bit_end;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (wr_en),
    .din  (data_in),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (full),
    .empty(fifo_empty)
  );

  assign bit_end = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign tx      = tx_q;
  assign busy    = (state_q != IDLE) || !fifo_empty;
  assign tx_done = (state_q == STOP) && bit_end;

  // tx_d carries the level of the bit being entered, so tx lines up with the state register.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          shift_d   = fifo_dout;
          fifo_pop  = 1'b1;
          bit_cnt_d = '0;
          clk_cnt_d = '0;
          tx_d      = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (!fifo_empty) begin
            shift_d   = fifo_dout;
            fifo_pop  = 1'b1;
            bit_cnt_d = '0;
            tx_d      = 1'b0;
            state_d   = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: fast instance (4 clocks/bit) plus a slow 868 clocks/bit instance.
module tb_uart_tx;

  localparam int unsigned CPB  = 4;
  localparam int unsigned SCPB = 868;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in, data_in_s;
  logic       wr_en, wr_en_s;
  logic       full, busy, tx_done, tx;
  logic       full_s, busy_s, tx_done_s, tx_s;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en),
    .full(full), .busy(busy), .tx_done(tx_done), .tx(tx)
  );

  uart_tx #(.CLKS_PER_BIT(SCPB), .FIFO_DEPTH(4)) dut_s (
    .clk(clk), .rst(rst), .data_in(data_in_s), .wr_en(wr_en_s),
    .full(full_s), .busy(busy_s), .tx_done(tx_done_s), .tx(tx_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int unsigned k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  // Entered #1 after an edge at frame cycle 'first'; leaves #1 after the edge ending the stop bit.
  task automatic check_frame(input logic [7:0] b, input int unsigned first, input bit inject);
    for (int unsigned i = first; i < 10 * CPB; i++) begin
      chk($sformatf("tx_%02h_c%0d", b, i), tx, frame_bit(b, i / CPB));
      chk($sformatf("done_%02h_c%0d", b, i), tx_done, (i == 10 * CPB - 1));
      if (inject && i == 10 * CPB - 1) begin
        chk("full_before_pop", full, 1'b1);
        data_in = 8'h77;
        wr_en   = 1'b1;
      end
      tick();
      wr_en = 1'b0;
    end
  endtask

  task automatic send_idle(input logic [7:0] b);
    data_in = b;
    wr_en   = 1'b1;
    tick();
    wr_en = 1'b0;
    chk($sformatf("busy_after_wr_%02h", b), busy, 1'b1);
    chk($sformatf("tx_high_after_wr_%02h", b), tx, 1'b1);
    tick();
    check_frame(b, 0, 1'b0);
    chk($sformatf("busy_end_%02h", b), busy, 1'b0);
    chk($sformatf("tx_idle_end_%02h", b), tx, 1'b1);
  endtask

  initial begin
    int unsigned bad, done_cnt;
    logic done_last;
    logic [7:0] sb;

    rst = 1'b1; wr_en = 1'b0; data_in = '0; wr_en_s = 1'b0; data_in_s = '0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post_rst_tx", tx, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_full_s", full_s, 1'b0);

    send_idle(8'hA5);

    // Burst: 0x01 popped immediately, 0x02..0x05 fill the FIFO, 0xFF dropped.
    for (int unsigned k = 1; k <= 5; k++) begin
      data_in = 8'(k);
      wr_en   = 1'b1;
      tick();
    end
    chk("burst_full", full, 1'b1);
    data_in = 8'hFF;
    tick();
    wr_en = 1'b0;
    chk("burst_full_after_drop", full, 1'b1);
    check_frame(8'h01, 4, 1'b1);
    chk("full_after_pop", full, 1'b0);
    check_frame(8'h02, 0, 1'b0);
    check_frame(8'h03, 0, 1'b0);
    check_frame(8'h04, 0, 1'b0);
    check_frame(8'h05, 0, 1'b0);
    chk("burst_busy_end", busy, 1'b0);
    chk("burst_tx_end", tx, 1'b1);
    tick();
    chk("burst_no_extra_frame", tx, 1'b1);

    // Reset mid-frame during data bit 3 of 0x30 with two bytes queued.
    data_in = 8'h30; wr_en = 1'b1; tick();
    data_in = 8'h11; tick();
    data_in = 8'h22; tick();
    wr_en = 1'b0;
    for (int unsigned k = 0; k < 16; k++) tick();
    chk("pre_rst_tx_bit3", tx, 1'b0);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_full", full, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    tick(); tick();
    rst = 1'b0;
    bad = 0;
    for (int unsigned k = 0; k < 50; k++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("post_rst_quiet", bad, 0);

    send_idle(8'h00);
    send_idle(8'hFF);

    // Slow instance: every bit period must be exactly SCPB cycles.
    sb = 8'h55;
    data_in_s = sb; wr_en_s = 1'b1;
    tick();
    wr_en_s = 1'b0;
    chk("slow_busy", busy_s, 1'b1);
    tick();
    done_cnt = 0;
    done_last = 1'b0;
    for (int unsigned k = 0; k < 10; k++) begin
      bad = 0;
      for (int unsigned c = 0; c < SCPB; c++) begin
        if (tx_s !== frame_bit(sb, k)) bad++;
        if (tx_done_s === 1'b1) done_cnt++;
        if (k == 9 && c == SCPB - 1) done_last = tx_done_s;
        tick();
      end
      chk($sformatf("slow_bit%0d", k), bad, 0);
    end
    chk("slow_done_cnt", done_cnt, 1);
    chk("slow_done_last", done_last, 1'b1);
    chk("slow_busy_end", busy_s, 1'b0);
    chk("slow_tx_end", tx_s, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
